// File: rtl/tms9919_pkg.sv
// Shared definitions for the tms9919 sound-list player: FSM encoding and list/mute byte constants.
// The mute sequence is present only when TMS9919_SNDLIST_MUTE_ON_STOP_EN is defined.
package tms9919_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StFetchCnt = 3'd1,
        StFetchCmd = 3'd2,
        StWrite    = 3'd3,
        StFetchDur = 3'd4,
        StWait     = 3'd5
`ifdef TMS9919_SNDLIST_MUTE_ON_STOP_EN
        ,
        StMute     = 3'd6
`endif
    } state_e;

    // A block whose duration byte is zero ends the list.
    localparam logic [7:0] ListTermDur = 8'h00;

`ifdef TMS9919_SNDLIST_MUTE_ON_STOP_EN
    // Maximum attenuation for tone 1, tone 2, tone 3 and noise.
    localparam logic [7:0] MuteByte0 = 8'h9F;
    localparam logic [7:0] MuteByte1 = 8'hBF;
    localparam logic [7:0] MuteByte2 = 8'hDF;
    localparam logic [7:0] MuteByte3 = 8'hFF;

    function automatic logic [7:0] mute_byte(input logic [1:0] idx);
        logic [7:0] b;
        unique case (idx)
            2'd0:    b = MuteByte0;
            2'd1:    b = MuteByte1;
            2'd2:    b = MuteByte2;
            default: b = MuteByte3;
        endcase
        return b;
    endfunction
`endif

endpackage

// File: rtl/tms9919_sndlist_player.sv
// Plays TI-format sound lists ([N][N cmd bytes][D] blocks) from memory into the tms9919 write port.
// Define TMS9919_SNDLIST_MUTE_ON_STOP_EN to silence all four channels on termination.
module tms9919_sndlist_player
    import tms9919_pkg::*;
#(
    parameter int unsigned AddrBits = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [AddrBits-1:0] start_addr_i,
    input  logic                stop_i,
    input  logic                frame_tick_i,
    output logic [AddrBits-1:0] mem_addr_o,
    output logic                mem_rd_o,
    input  logic                mem_ack_i,
    input  logic [7:0]          mem_data_i,
    output logic [7:0]          snd_d_o,
    output logic                snd_cs_o,
    output logic                snd_we_o,
    input  logic                snd_ready_i,
    output logic                busy_o,
    output logic                done_o
);

    state_e              state_q;
    logic [AddrBits-1:0] ptr_q;
    logic [AddrBits-1:0] mem_addr_q;
    logic                mem_rd_q;
    logic [7:0]          snd_d_q;
    logic [7:0]          cnt_q;
    logic [7:0]          delay_q;
    logic                busy_q;
    logic                done_q;
`ifdef TMS9919_SNDLIST_MUTE_ON_STOP_EN
    logic [1:0]          mute_idx_q;
`endif

    logic fetch_st;
    logic ack_ok;
    logic stop_ok;
    logic term;
    logic wr_fire;

    always_comb begin
        fetch_st = (state_q == StFetchCnt) || (state_q == StFetchCmd) || (state_q == StFetchDur);
        ack_ok   = fetch_st && mem_rd_q && mem_ack_i;
        stop_ok  = stop_i && (fetch_st || (state_q == StWrite) || (state_q == StWait));
        term     = stop_ok || (ack_ok && (state_q == StFetchDur) && (mem_data_i == ListTermDur));
        // Strobe is gated directly by ready so the write cycle is exactly the ready cycle.
        wr_fire  = (state_q == StWrite) && snd_ready_i && !stop_i;
`ifdef TMS9919_SNDLIST_MUTE_ON_STOP_EN
        if (state_q == StMute) begin
            wr_fire = snd_ready_i;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            snd_d_q    <= 8'h00;
            cnt_q      <= 8'h00;
            delay_q    <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef TMS9919_SNDLIST_MUTE_ON_STOP_EN
            mute_idx_q <= 2'd0;
`endif
        end else begin
            done_q <= 1'b0;
            if (term) begin
                mem_rd_q <= 1'b0;
`ifdef TMS9919_SNDLIST_MUTE_ON_STOP_EN
                state_q    <= StMute;
                mute_idx_q <= 2'd0;
                snd_d_q    <= mute_byte(2'd0);
`else
                state_q <= StIdle;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
`endif
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            ptr_q   <= start_addr_i;
                            busy_q  <= 1'b1;
                            state_q <= StFetchCnt;
                        end
                    end
                    StFetchCnt, StFetchCmd, StFetchDur: begin
                        // mem_rd_q is low for the cycle after every ack, giving the idle gap.
                        if (!mem_rd_q) begin
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= ptr_q;
                        end else if (mem_ack_i) begin
                            mem_rd_q <= 1'b0;
                            ptr_q    <= ptr_q + AddrBits'(1);
                            if (state_q == StFetchCnt) begin
                                cnt_q   <= mem_data_i;
                                state_q <= (mem_data_i != 8'h00) ? StFetchCmd : StFetchDur;
                            end else if (state_q == StFetchCmd) begin
                                snd_d_q <= mem_data_i;
                                state_q <= StWrite;
                            end else begin
                                delay_q <= mem_data_i;
                                state_q <= StWait;
                            end
                        end
                    end
                    StWrite: begin
                        if (wr_fire) begin
                            cnt_q   <= cnt_q - 8'd1;
                            state_q <= (cnt_q == 8'd1) ? StFetchDur : StFetchCmd;
                        end
                    end
                    StWait: begin
                        if (frame_tick_i) begin
                            delay_q <= delay_q - 8'd1;
                            if (delay_q == 8'd1) begin
                                state_q <= StFetchCnt;
                            end
                        end
                    end
`ifdef TMS9919_SNDLIST_MUTE_ON_STOP_EN
                    StMute: begin
                        if (wr_fire) begin
                            if (mute_idx_q == 2'd3) begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                mute_idx_q <= mute_idx_q + 2'd1;
                                snd_d_q    <= mute_byte(mute_idx_q + 2'd1);
                            end
                        end
                    end
`endif
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign mem_addr_o = mem_addr_q;
    assign mem_rd_o   = mem_rd_q;
    assign snd_d_o    = snd_d_q;
    assign snd_cs_o   = wr_fire;
    assign snd_we_o   = wr_fire;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: doc/tms9919_sndlist_player.md
Name: tms9919_sndlist_player

Overview:
- Autonomous initiator that plays TI-format sound lists into the tms9919 sound generator's byte-write port (d/cs/we/ready).
- Fetches list bytes from system memory over a simple request/acknowledge read port.
- Issues the fetched command bytes to the sound generator, then waits a programmed number of frame ticks before the next block.
- Sits between the memory arbiter and the sound generator. Replaces the CPU's interrupt-driven sound-list routine.

Parameters:
addr_bits, 16, width of memory byte address; address arithmetic wraps modulo 2^addr_bits

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: begin playing list at start_addr
start_addr  in  addr_bits  byte address of first list block
stop  in  1  one-cycle pulse: abort playback
frame_tick  in  1  one-cycle pulse per video frame (60 Hz)
mem_addr  out  addr_bits  read address
mem_rd  out  1  read request, held until mem_ack
mem_ack  in  1  read data valid this cycle
mem_data  in  8  read data
snd_d  out  8  byte to sound generator
snd_cs  out  1  sound chip select
snd_we  out  1  sound write enable
snd_ready  in  1  sound generator ready
busy  out  1  high from start until playback ends
done  out  1  one-cycle pulse when playback ends (terminator, stop, or mute completion)

Behaviour:
- Reset: all outputs 0 (mem_addr, snd_d = 0; mem_rd, snd_cs, snd_we, busy, done = 0). FSM goes to IDLE, counters clear.
- List format: repeated blocks of [count N][N command bytes][duration D].
  - N=0 is legal: no writes, delay only.
  - D=0 terminates the list after that block's writes.
- FSM states: IDLE, FETCH_CNT, FETCH_CMD, WRITE, FETCH_DUR, WAIT, MUTE (MUTE only with the optional feature).
- IDLE:
  - start loads the pointer from start_addr, sets busy, goes to FETCH_CNT.
  - start is ignored while busy.
- Fetch states:
  - mem_rd=1 with mem_addr = pointer, both stable until mem_ack.
  - On the mem_ack cycle: capture mem_data, increment the pointer (with wrap), drop mem_rd next cycle.
  - Minimum of one cycle between successive requests (mem_rd is low for at least one cycle).
- FETCH_CNT → FETCH_CMD if N≠0, else FETCH_DUR.
- FETCH_CMD → WRITE.
- WRITE:
  - snd_d = byte. snd_cs = snd_we = 1 for exactly one cycle, in which snd_ready=1.
  - While snd_ready=0, hold snd_cs/snd_we low and snd_d stable.
  - After the write, decrement the remaining count. Go to FETCH_CMD if the count ≠0, else FETCH_DUR.
- FETCH_DUR → WAIT with the delay counter = D if D≠0. If D=0, terminate.
- WAIT:
  - Each frame_tick decrements the counter. When it reaches 0, go to FETCH_CNT.
  - A frame_tick in the same cycle the state is entered is not counted.
  - D=255 waits 255 ticks.
- Terminate: go to MUTE if the feature is enabled, otherwise IDLE. On entry to IDLE: busy=0, done pulses 1 cycle.
- stop while busy:
  - Abandons any outstanding read (mem_rd drops next cycle; a late mem_ack is ignored). Then terminate as above.
  - stop takes priority over a simultaneous mem_ack, write, or frame_tick.
  - stop in IDLE is ignored. stop during MUTE is ignored.
- Simultaneous start and stop in IDLE: start wins.
- The pointer wraps from 2^addr_bits-1 to 0 without error.

Optional Feature:
- Macro: TMS9919_SNDLIST_MUTE_ON_STOP_EN.
- Defined: on termination (D=0 or stop), MUTE writes 0x9F, 0xBF, 0xDF, 0xFF in that order, with the same ready rules as WRITE. busy stays high; done pulses after the last write.
- Undefined: the MUTE state and its constants are absent. Termination goes straight to IDLE; generator attenuations are left unchanged.

Decomposition:
- Shared package tms9919_pkg holds:
  - FSM state encoding
  - the four mute byte constants
  - list format constants (terminator duration 0).
- No sub-module. The fetch handshake is small enough to stay inline in the FSM.

Test Plan:
- List at 0x1000 = 03 9F 8E 0F 02 00: start → three single-cycle writes 0x9F, 0x8E, 0x0F; wait 2 frame_ticks; read count 00 at 0x1005 → delay-only block.
  - Extend with duration 00: done pulse, busy=0.
- Same list with snd_ready held low 5 cycles during the 2nd write → snd_d=0x8E stable, no cs/we until ready, no byte lost or duplicated.
- mem_ack delayed 0–7 random cycles per read → mem_addr/mem_rd stable while waiting; write sequence identical to zero-latency run.
- stop asserted in WAIT with 10 ticks remaining:
  - Macro off: done next cycle, no writes.
  - Macro on: writes 9F BF DF FF, then done.
- start_addr = 0xFFFE (addr_bits=16), list 01 9F 00 → reads at 0xFFFE, 0xFFFF, 0x0000; one write 0x9F; terminates.
- Reset asserted mid-WRITE with snd_ready low → all outputs 0 immediately (async); after release, start ignored until a new pulse, busy=0.
